fifo_param: RTL and testbench

Parametrised synchronous FIFO. It generalises the team's fixed 8x8 FIFO to arbitrary data width and power-of-two depth. It adds programmable almost-full/almost-empty thresholds, an occupancy count output, simultaneous read/write at full, a read-valid strobe and a sticky error flag with clear. It sits between producer and consumer blocks in the same clock domain and is the drop-in buffer for the next-generation datapath.

---
 rtl/fifo_param_if.sv | 37 +++
 rtl/fifo_param.sv | 149 ++++++++++++++
 tb/tb_fifo_param.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// fifo_param_if: producer/consumer and status signals of the parametrised FIFO.
interface fifo_param_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    // Requests from the producer/consumer side
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic                  err_clr;

    // Data and status returned by the FIFO
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_W:0]       count;
    logic                  wr_error;
    logic                  rd_error;
    logic                  error;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, wr_error, rd_error, error
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, wr_error, rd_error, error
    );
endinterface

// File: rtl/fifo_param.sv
// fifo_param: single-clock FIFO with registered status flags, occupancy count,
// read-valid strobe, reject pulses and a sticky error flag.
module fifo_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic           clk,
    input  logic           reset,
    fifo_param_if.slave    bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    // Reject illegal configurations at elaboration time
    generate
        if (DEPTH < 2) begin : g_depth_min
            $error("fifo_param: DEPTH must be >= 2");
        end
        if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_pow2
            $error("fifo_param: DEPTH must be a power of two");
        end
        if (AE_LEVEL < 1) begin : g_ae_min
            $error("fifo_param: AE_LEVEL must be >= 1");
        end
        if (AE_LEVEL >= AF_LEVEL) begin : g_ae_af
            $error("fifo_param: AE_LEVEL must be below AF_LEVEL");
        end
        if (AF_LEVEL > DEPTH - 1) begin : g_af_max
            $error("fifo_param: AF_LEVEL must be <= DEPTH-1");
        end
    endgenerate

    // Storage (not reset) and pointers
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;

    // Occupancy and status flags
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;

    // Read data path and error reporting
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_error_q, wr_error_d;
    logic                  rd_error_q, rd_error_d;
    logic                  error_q, error_d;

    // Accept decisions; a write at full rides on a same-cycle accepted read
    logic rd_acc_c;
    logic wr_acc_c;

    // Accept logic from the registered flags
    always_comb begin
        rd_acc_c = bus.rd_en && !empty_q;
        wr_acc_c = bus.wr_en && (!full_q || rd_acc_c);
    end

    // Next-state for pointers, count, flags, read data and errors
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        count_d = count_q + CNT_W'(wr_acc_c) - CNT_W'(rd_acc_c);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CNT_W'(AF_LEVEL));
        ae_d    = (count_d <= CNT_W'(AE_LEVEL));

        wr_error_d = bus.wr_en && !wr_acc_c;
        rd_error_d = bus.rd_en && empty_q;

        // Setting a new error takes priority over a same-cycle clear
        error_d = error_q;
        if (bus.err_clr) begin
            error_d = 1'b0;
        end
        if (wr_error_d || rd_error_d) begin
            error_d = 1'b1;
        end
    end

    // Memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    // Control and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_error_q <= 1'b0;
            rd_error_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_error_q <= wr_error_d;
            rd_error_q <= rd_error_d;
            error_q    <= error_d;
        end
    end

    // Drive the interface straight from the registers
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.wr_error     = wr_error_q;
    assign bus.rd_error     = rd_error_q;
    assign bus.error        = error_q;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed vector table, mid-operation reset sequence and a
// randomized run against a queue-based reference model.
module tb_fifo_param;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    fifo_param #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          we;
        logic [DW-1:0] wd;
        logic          re;
        logic          ec;
        int            cnt;
        logic          fl;
        logic          em;
        logic          af;
        logic          ae;
        logic          rv;
        logic [DW-1:0] rd;
        logic          werr;
        logic          rerr;
        logic          err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic we, input int wd, input logic re, input logic ec,
                                input int cnt, input logic fl, input logic em, input logic af,
                                input logic ae, input logic rv, input int rd,
                                input logic werr, input logic rerr, input logic err);
        vec_t v;
        v.we = we; v.wd = DW'(wd); v.re = re; v.ec = ec;
        v.cnt = cnt; v.fl = fl; v.em = em; v.af = af; v.ae = ae;
        v.rv = rv; v.rd = DW'(rd); v.werr = werr; v.rerr = rerr; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int cnt, input logic fl, input logic em,
                             input logic af, input logic ae, input logic rv, input logic [DW-1:0] rd,
                             input logic werr, input logic rerr, input logic err);
        check({tag, ".count"},        32'(bus.count),        32'(cnt));
        check({tag, ".full"},         32'(bus.full),         32'(fl));
        check({tag, ".empty"},        32'(bus.empty),        32'(em));
        check({tag, ".almost_full"},  32'(bus.almost_full),  32'(af));
        check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
        check({tag, ".rd_valid"},     32'(bus.rd_valid),     32'(rv));
        check({tag, ".rd_data"},      32'(bus.rd_data),      32'(rd));
        check({tag, ".wr_error"},     32'(bus.wr_error),     32'(werr));
        check({tag, ".rd_error"},     32'(bus.rd_error),     32'(rerr));
        check({tag, ".error"},        32'(bus.error),        32'(err));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [DW-1:0] wd, input logic re, input logic ec);
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.err_clr = ec;
    endtask

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd;
    logic          m_err;

    initial begin
        // Fill from empty to full, then overflow, clear, read-while-full, drain
        tbl.push_back(mk(1, 'h11, 0, 0, 1, 0, 0, 0, 1, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(1, 'h22, 0, 0, 2, 0, 0, 0, 1, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(1, 'h33, 0, 0, 3, 0, 0, 0, 0, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(1, 'h44, 0, 0, 4, 0, 0, 0, 0, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(1, 'h55, 0, 0, 5, 0, 0, 0, 0, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(1, 'h66, 0, 0, 6, 0, 0, 1, 0, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(1, 'h77, 0, 0, 7, 0, 0, 1, 0, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(1, 'h88, 0, 0, 8, 1, 0, 1, 0, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(1, 'h99, 0, 0, 8, 1, 0, 1, 0, 0, 'h00, 1, 0, 1));
        tbl.push_back(mk(0, 'h00, 0, 0, 8, 1, 0, 1, 0, 0, 'h00, 0, 0, 1));
        tbl.push_back(mk(0, 'h00, 0, 1, 8, 1, 0, 1, 0, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(1, 'hAA, 1, 0, 8, 1, 0, 1, 0, 1, 'h11, 0, 0, 0));
        tbl.push_back(mk(0, 'h00, 1, 0, 7, 0, 0, 1, 0, 1, 'h22, 0, 0, 0));
        tbl.push_back(mk(0, 'h00, 1, 0, 6, 0, 0, 1, 0, 1, 'h33, 0, 0, 0));
        tbl.push_back(mk(0, 'h00, 1, 0, 5, 0, 0, 0, 0, 1, 'h44, 0, 0, 0));
        tbl.push_back(mk(0, 'h00, 1, 0, 4, 0, 0, 0, 0, 1, 'h55, 0, 0, 0));
        tbl.push_back(mk(0, 'h00, 1, 0, 3, 0, 0, 0, 0, 1, 'h66, 0, 0, 0));
        tbl.push_back(mk(0, 'h00, 1, 0, 2, 0, 0, 0, 1, 1, 'h77, 0, 0, 0));
        tbl.push_back(mk(0, 'h00, 1, 0, 1, 0, 0, 0, 1, 1, 'h88, 0, 0, 0));
        tbl.push_back(mk(0, 'h00, 1, 0, 0, 0, 1, 0, 1, 1, 'hAA, 0, 0, 0));
        tbl.push_back(mk(0, 'h00, 0, 0, 0, 0, 1, 0, 1, 0, 'hAA, 0, 0, 0));
        // Read+write at empty: write wins, read rejected, no pass-through
        tbl.push_back(mk(1, 'h5C, 1, 0, 1, 0, 0, 0, 1, 0, 'hAA, 0, 1, 1));
        tbl.push_back(mk(0, 'h00, 1, 0, 0, 0, 1, 0, 1, 1, 'h5C, 0, 0, 1));
        tbl.push_back(mk(0, 'h00, 0, 0, 0, 0, 1, 0, 1, 0, 'h5C, 0, 0, 1));
        tbl.push_back(mk(0, 'h00, 0, 1, 0, 0, 1, 0, 1, 0, 'h5C, 0, 0, 0));

        // Reset state
        reset = 1'b1;
        drive(0, '0, 0, 0);
        tick();
        tick();
        check_all("reset", 0, 0, 1, 0, 1, 0, '0, 0, 0, 0);
        reset = 1'b0;

        // Directed vector table
        foreach (tbl[i]) begin
            drive(tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].ec);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].fl, tbl[i].em, tbl[i].af,
                      tbl[i].ae, tbl[i].rv, tbl[i].rd, tbl[i].werr, tbl[i].rerr, tbl[i].err);
        end

        // Reset with entries buffered and a read requested
        for (int i = 0; i < 3; i++) begin
            drive(1, DW'(8'hC0 + i), 0, 0);
            tick();
        end
        check("pre_rst.count", 32'(bus.count), 32'd3);
        drive(0, '0, 1, 0);
        reset = 1'b1;
        tick();
        check_all("mid_rst", 0, 0, 1, 0, 1, 0, '0, 0, 0, 0);
        reset = 1'b0;
        tick();
        check_all("post_rst_rd", 0, 0, 1, 0, 1, 0, '0, 0, 1, 1);
        drive(0, '0, 0, 1);
        tick();
        check("post_rst_clr.error", 32'(bus.error), 32'd0);

        // Randomized run against a queue reference model
        drive(0, '0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        m_rd  = '0;
        m_err = 1'b0;
        for (int cyc = 0; cyc < 160; cyc++) begin
            logic          we, re, ec, racc, wacc, mrv, mwe, mre;
            logic [DW-1:0] wd;
            int            wpct;
            // Alternate write-heavy and read-heavy phases to reach full and empty
            wpct = ((cyc / 20) % 2 == 0) ? 75 : 25;
            we = ($urandom_range(99) < wpct);
            re = ($urandom_range(99) >= wpct);
            ec = ($urandom_range(7) == 0);
            wd = DW'($urandom);

            racc = re && (q.size() > 0);
            wacc = we && ((q.size() < DEPTH) || racc);
            mrv  = racc;
            mwe  = we && !wacc;
            mre  = re && !racc;
            if (racc) m_rd = q.pop_front();
            if (wacc) q.push_back(wd);
            if (mwe || mre) m_err = 1'b1;
            else if (ec)    m_err = 1'b0;

            drive(we, wd, re, ec);
            tick();
            check_all($sformatf("rnd%0d", cyc), q.size(), q.size() == DEPTH, q.size() == 0,
                      q.size() >= AF, q.size() <= AE, mrv, m_rd, mwe, mre, m_err);
        end
        drive(0, '0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
